// File: rtl/ex_muldiv.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : ex_muldiv                                                        |
// | Purpose  : Iterative RV64M multiply/divide unit (shift-add / restoring)     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [3:0]  op_i,
  input  logic [63:0] src1_i,
  input  logic [63:0] src2_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        stall_o,
  output logic        valid_o,
  output logic [63:0] result_o,
  output logic [4:0]  rd_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [6:0] c_N64 = 7'd64;
  localparam logic [6:0] c_N32 = 7'd32;

  state_t      r_state;
  logic [6:0]  r_cnt;
  logic [3:0]  r_op;
  logic        r_neg;
  logic [63:0] r_hi;
  logic [63:0] r_a;
  logic [63:0] r_b;
  logic [63:0] r_result;
  logic [4:0]  r_rd;
  logic        r_valid;

  logic        w_is_w, w_is_div, w_rsvd, w_sgn1, w_sgn2, w_s1, w_s2;
  logic        w_div0, w_ovf, w_special;
  logic [63:0] w_x1, w_x2, w_m1, w_m2, w_dvd_ext, w_special_res;

  // Operand decode for the op waiting at the input
  always_comb begin
    w_is_w    = op_i[3];
    w_is_div  = op_i[2];
    w_rsvd    = op_i[3] & ~op_i[2] & (op_i[1:0] != 2'b00);
    w_sgn1    = w_is_div ? ~op_i[0] : (~w_is_w & (op_i[1:0] != 2'b11));
    w_sgn2    = w_is_div ? ~op_i[0] : (~w_is_w & ~op_i[1]);
    w_x1      = w_is_w ? {{32{w_sgn1 & src1_i[31]}}, src1_i[31:0]} : src1_i;
    w_x2      = w_is_w ? {{32{w_sgn2 & src2_i[31]}}, src2_i[31:0]} : src2_i;
    w_s1      = w_sgn1 & w_x1[63];
    w_s2      = w_sgn2 & w_x2[63];
    w_m1      = w_s1 ? (~w_x1 + 64'd1) : w_x1;
    w_m2      = w_s2 ? (~w_x2 + 64'd1) : w_x2;
    w_dvd_ext = w_is_w ? {{32{src1_i[31]}}, src1_i[31:0]} : src1_i;
    w_div0    = w_is_div & (w_x2 == 64'd0);
    if (w_is_w)
      w_ovf = w_is_div & ~op_i[0] & (src1_i[31:0] == 32'h8000_0000) &
              (src2_i[31:0] == 32'hFFFF_FFFF);
    else
      w_ovf = w_is_div & ~op_i[0] & (src1_i == 64'h8000_0000_0000_0000) &
              (src2_i == 64'hFFFF_FFFF_FFFF_FFFF);
    w_special = w_rsvd | w_div0 | w_ovf;
    w_special_res = 64'd0;
    if (w_div0)
      w_special_res = op_i[1] ? w_dvd_ext : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (w_ovf)
      w_special_res = op_i[1] ? 64'd0 : w_dvd_ext;
  end

  logic [64:0] w_sum, w_trial;
  logic [63:0] w_shift_lo, w_hi_n, w_a_n;

  // One iteration: shift-add for multiply, restoring step for divide
  always_comb begin
    w_sum      = {1'b0, r_hi} + (r_a[0] ? {1'b0, r_b} : 65'd0);
    w_trial    = {r_hi, r_a[63]} - {1'b0, r_b};
    w_shift_lo = {r_hi[62:0], r_a[63]};
    if (r_op[2]) begin
      w_hi_n = w_trial[64] ? w_shift_lo : w_trial[63:0];
      w_a_n  = {r_a[62:0], ~w_trial[64]};
    end else begin
      w_hi_n = w_sum[64:1];
      w_a_n  = {w_sum[0], r_a[63:1]};
    end
  end

  logic [127:0] w_prod;
  logic [63:0]  w_q, w_r, w_dres, w_fin;

  always_comb begin
    w_prod = r_neg ? (~{w_hi_n, w_a_n} + 128'd1) : {w_hi_n, w_a_n};
    w_q    = r_neg ? (~w_a_n + 64'd1) : w_a_n;
    w_r    = r_neg ? (~w_hi_n + 64'd1) : w_hi_n;
    w_dres = r_op[1] ? w_r : w_q;
    if (r_op[2])
      w_fin = r_op[3] ? {{32{w_dres[31]}}, w_dres[31:0]} : w_dres;
    else if (r_op[3])
      w_fin = {{32{w_a_n[63]}}, w_a_n[63:32]};
    else if (r_op[1:0] == 2'b00)
      w_fin = w_prod[63:0];
    else
      w_fin = w_prod[127:64];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 7'd0;
      r_op     <= 4'd0;
      r_neg    <= 1'b0;
      r_hi     <= 64'd0;
      r_a      <= 64'd0;
      r_b      <= 64'd0;
      r_result <= 64'd0;
      r_rd     <= 5'd0;
      r_valid  <= 1'b0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 7'd0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_op <= op_i;
            r_rd <= rd_i;
            r_hi <= 64'd0;
            if (w_special) begin
              r_result <= w_special_res;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_CALC;
              r_cnt   <= w_is_w ? c_N32 : c_N64;
              if (w_is_div) begin
                r_a   <= w_is_w ? {w_m1[31:0], 32'd0} : w_m1;
                r_b   <= w_m2;
                r_neg <= op_i[1] ? w_s1 : (w_s1 ^ w_s2);
              end else begin
                r_a   <= w_m2;
                r_b   <= w_m1;
                r_neg <= w_s1 ^ w_s2;
              end
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_n;
          r_a   <= w_a_n;
          r_cnt <= r_cnt - 7'd1;
          if (r_cnt == 7'd1) begin
            r_result <= w_fin;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o  = (r_state == S_IDLE);
  assign stall_o  = valid_i && (r_state != S_DONE);
  assign valid_o  = r_valid;
  assign result_o = r_result;
  assign rd_o     = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_ex_muldiv                                                     |
// | Purpose  : Scoreboard bench for ex_muldiv with directed vectors             |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [3:0]  op_i;
  logic [63:0] src1_i;
  logic [63:0] src2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        ready_o;
  logic        stall_o;
  logic        valid_o;
  logic [63:0] result_o;
  logic [4:0]  rd_o;

  ex_muldiv dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .op_i     (op_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .ready_o  (ready_o),
    .stall_o  (stall_o),
    .valid_o  (valid_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (valid_o) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got result %h with no op outstanding (cycle %0d)",
                 result_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("rd", {59'd0, rd_o}, {59'd0, e.rd});
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one op in the current cycle; holds valid_i until the op retires
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input logic [63:0] exp, input int lat);
    int   n;
    exp_t e;
    valid_i = 1'b1;
    op_i    = op;
    src1_i  = a;
    src2_i  = b;
    rd_i    = rd;
    e.res   = exp;
    e.rd    = rd;
    e.cyc   = cyc + lat;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall_o && n < 200);
    chk("stall_cycles", n, lat + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    op_i    = 4'd0;
    src1_i  = 64'd0;
    src2_i  = 64'd0;
    rd_i    = 5'd0;
    flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_ready", {63'd0, ready_o}, 64'd1);
    chk("reset_valid", {63'd0, valid_o}, 64'd0);
    chk("reset_stall", {63'd0, stall_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_rd", {59'd0, rd_o}, 64'd0);

    run_op(4'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd5, 64'hFFFF_FFFF_FFFF_FFF1, 65);   // MUL
    idle();
    run_op(4'd3, c_ONES, c_ONES, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65);                   // MULHU
    idle();
    run_op(4'd1, c_ONES, c_ONES, 5'd7, 64'd0, 65);                                     // MULH
    idle();
    run_op(4'd1, 64'h8000_0000_0000_0000, 64'd2, 5'd8, c_ONES, 65);                     // MULH
    idle();
    run_op(4'd2, c_ONES, 64'd2, 5'd9, c_ONES, 65);                                     // MULHSU
    idle();
    run_op(4'd8, 64'hABCD_0000_4000_0000, 64'd3, 5'd10, 64'hFFFF_FFFF_C000_0000, 33);  // MULW
    idle();
    run_op(4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFD, 65);  // DIV
    idle();
    run_op(4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd12, c_ONES, 65);                   // REM
    idle();
    run_op(4'd13, 64'd7, 64'd2, 5'd13, 64'd3, 33);                                     // DIVUW
    idle();
    run_op(4'd14, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd14, c_ONES, 33);                  // REMW
    idle();
    run_op(4'd5, 64'd5, 64'd0, 5'd15, c_ONES, 1);                                      // DIVU /0
    idle();
    run_op(4'd7, 64'd5, 64'd0, 5'd16, 64'd5, 1);                                       // REMU /0
    idle();
    run_op(4'd12, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd17,
           64'hFFFF_FFFF_8000_0000, 1);                                                // DIVW ovf
    idle();
    run_op(4'd14, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd18, 64'd0, 1);  // REMW ovf
    idle();
    run_op(4'd9, 64'd123, 64'd456, 5'd19, 64'd0, 1);                                   // reserved
    idle();

    // Back-to-back MULs with valid_i held across the boundary
    run_op(4'd0, 64'd7, 64'd6, 5'd20, 64'd42, 65);
    run_op(4'd0, 64'd12345, 64'd1000, 5'd21, 64'd12345000, 65);
    idle();

    // Flush in cycle 10 of a DIV
    valid_i = 1'b1;
    op_i    = 4'd4;
    src1_i  = 64'hFFFF_FFFF_FFFF_FFF9;
    src2_i  = 64'd2;
    rd_i    = 5'd22;
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush_ready", {63'd0, ready_o}, 64'd1);
    run_op(4'd5, 64'd100, 64'd7, 5'd23, 64'd14, 65);
    idle();

    // Reset in cycle 10 of a DIV
    valid_i = 1'b1;
    op_i    = 4'd4;
    src1_i  = 64'hFFFF_FFFF_FFFF_FFF9;
    src2_i  = 64'd2;
    rd_i    = 5'd24;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", {63'd0, ready_o}, 64'd1);
    chk("rst_result", result_o, 64'd0);
    chk("rst_rd", {59'd0, rd_o}, 64'd0);
    run_op(4'd7, 64'd100, 64'd7, 5'd25, 64'd2, 65);
    idle();

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV64M multiply/divide unit on the consumer side of the ID/EX pipeline register. It accepts one M-extension operation from the EX stage and holds the ID/EX register via `stall_o` while it computes. It returns a single-cycle result pulse tagged with the destination register. Multiply uses shift-add and divide uses restoring division, one bit per cycle.

## Interface
- Parameters: none (XLEN fixed at 64).
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_i` in 1: EX stage holds an M-extension op; stays high until the op retires.
- `op_i` in 4: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW; 9–11 reserved.
- `src1_i` in 64: rs1 operand (dividend / multiplicand).
- `src2_i` in 64: rs2 operand (divisor / multiplier).
- `rd_i` in 5: destination tag.
- `flush_i` in 1: abort the current op (branch/jump redirect).
- `ready_o` out 1: unit idle, can accept.
- `stall_o` out 1: combinational; `valid_i && state!=DONE`; holds ID/EX and earlier stages.
- `valid_o` out 1: result valid, one-cycle pulse.
- `result_o` out 64: result; holds its value between pulses.
- `rd_o` out 5: tag captured at accept.

## Operation
- States: IDLE, CALC, DONE. `ready_o = (state==IDLE)`.
- Accept:
  - Occurs when `valid_i && ready_o && !flush_i`.
  - Capture operands, op and `rd_i`.
  - If the op is a special case, go to DONE; otherwise go to CALC with counter N.
- N = 64 for 64-bit ops, 32 for W ops.
- CALC:
  - Process one bit per cycle, decrementing the counter.
  - When the counter reaches 0, go to DONE.
- DONE:
  - Assert `valid_o` and drive `result_o`/`rd_o`.
  - Go to IDLE unconditionally. `valid_i` is still high here for the same instruction and must not cause a re-accept.
- W ops:
  - Operands come from bits [31:0], sign-extended (DIVW/REMW) or zero-extended (DIVUW/REMUW, MULW).
  - The 32-bit result is sign-extended to 64.
- Signed handling:
  - Compute on magnitudes, then fix up the sign.
  - Product sign = sign1 XOR sign2. This applies only to signed operands; for MULHSU only src1 is signed.
  - Quotient sign = sign1 XOR sign2. Remainder takes the sign of the dividend.
- MUL/MULW return the low 64/32 bits of the product. MULH* return the high 64 bits of the 128-bit product.
- Special cases (no CALC):
  - Divide by zero: quotient = all ones (at the op width, then extended); remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = dividend, remainder = 0.
  - Reserved op codes: result 0.
- Flush:
  - `flush_i` has priority over everything except `rst`.
  - In any state, the next state is IDLE, `valid_o` is 0 next cycle, and no result is written.
  - `flush_i` in the accept cycle blocks the accept.
- Reset: state IDLE, `valid_o` 0, `result_o` 0, `rd_o` 0, counter 0, so `ready_o` is 1. Reset mid-CALC discards the op.

## Timing
- Cycle 0 is the accept cycle.
- Normal op: cycles 1..N are CALC; `valid_o` is high in cycle N+1.
  - 64-bit ops: `valid_o` in cycle 65.
  - W ops: `valid_o` in cycle 33.
- Special case: `valid_o` in cycle 1.
- `stall_o` is high in cycles 0..N and low in the DONE cycle, so ID/EX advances on the same edge the result is consumed.
- `ready_o` returns high in cycle N+2 (special case: cycle 2). A back-to-back op is accepted in that cycle; there is no turnaround bubble beyond DONE.
- `valid_o` is never high for two consecutive cycles.

## Test plan
- MUL 3 × −5 (src2=0xFFFF_FFFF_FFFF_FFFB) → cycle 65: `valid_o`=1, result 0xFFFF_FFFF_FFFF_FFF1, `rd_o`=`rd_i`; `stall_o` high in cycles 0–64.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × same → 0xFFFF_FFFF_FFFF_FFFE; MULH with the same operands → 0.
- DIV −7/2 → 0xFFFF_FFFF_FFFF_FFFD; REM −7/2 → 0xFFFF_FFFF_FFFF_FFFF; DIVUW 7/2 → 3 in cycle 33.
- DIVU 5/0 → 0xFFFF_FFFF_FFFF_FFFF in cycle 1.
  - REMU 5/0 → 5.
  - DIVW 0x8000_0000 / 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000 in cycle 1.
  - REMW with the same operands → 0.
- `flush_i` pulse in cycle 10 of DIV → no `valid_o` ever; `ready_o`=1 in cycle 11; a new op is accepted in cycle 11 and completes normally. Repeat the check with `rst` in place of `flush_i`: `result_o`=0 afterwards.
- Two back-to-back MULs with `valid_i` held → second accepted in cycle 66, `valid_o` pulses in cycles 65 and 131 only.
